wl_afifo_rctrl: RTL and testbench
=================================

Name: wl_afifo_rctrl

Overview:
- Complete read-domain controller for the wl async FIFO family, with parametrised depth.
- Owns the read pointer in binary, gray and RAM-address form.
- Converts the synchronised gray write pointer to binary and produces registered empty, runtime-programmable almost-empty, fill level and a sticky underflow flag.
- Sits between the rclk-side 2-flop synchroniser of the write pointer and the FIFO RAM read port.

Parameters:
- AW, 3: RAM address width; depth = 2**AW; all pointers are AW+1 bits.
- TB_DEF, 2: almost-empty threshold used when ae_thresh_vld is low.

Ports:
- rclk  input  1  read clock
- rrst_b  input  1  reset
- rclr  input  1  synchronous read-side clear
- rd_en  input  1  read request
- r2_gray_wptr  input  AW+1  gray write pointer, already synchronised to rclk
- ae_thresh  input  AW+1  runtime almost-empty threshold
- ae_thresh_vld  input  1  1: use ae_thresh; 0: use TB_DEF
- ae_hyst  input  AW+1  deassert hysteresis (used only with the macro)
- rd_ok  output  1  read accepted this cycle (combinational)
- raddr  output  AW  RAM read address
- bin_rptr  output  AW+1  binary read pointer
- gray_rptr  output  AW+1  gray read pointer, to the wclk synchroniser
- rempty  output  1  empty flag, registered
- arempty  output  1  almost-empty flag, registered
- rlevel  output  AW+1  fill level as seen from rclk, registered
- underflow  output  1  sticky underflow error

Behaviour:
- Reset and clock: rrst_b is asynchronous, active-low; rclk is the clock. All state is on posedge rclk.
- Reset values: bin_rptr=0, gray_rptr=0, rempty=1, arempty=1, rlevel=0, underflow=0.
- Derived outputs: raddr = bin_rptr[AW-1:0]. rd_ok = rd_en & ~rempty & ~rclr.
- Next read pointer: bin_rptr_nxt = bin_rptr + rd_ok, modulo 2**(AW+1), wrapping naturally. gray_rptr_nxt = bin_rptr_nxt ^ (bin_rptr_nxt >> 1). Both are registered.
- Write pointer conversion: r2_bin_wptr is computed by iterative gray-to-binary conversion with MSB first, i.e. bit i = XOR of gray bits i..AW.
- Level: rlevel_nxt = r2_bin_wptr - bin_rptr_nxt, modulo 2**(AW+1). The valid range is 0..2**AW.
- Empty: rempty_nxt = (gray_rptr_nxt == r2_gray_wptr). It is evaluated on the next pointer, so a read that takes the last word asserts rempty in the following cycle with no bubble.
- Almost-empty threshold: thr = ae_thresh_vld ? ae_thresh : TB_DEF.
  - Without the macro: arempty_nxt = (rlevel_nxt <= thr).
- Read latency: rd_ok in cycle N means RAM data at raddr(N) is presented per RAM latency, which is outside this block. The pointer advances at edge N+1.
- rclr (synchronous, priority below reset):
  - pointers hold;
  - rempty and arempty are forced to 1 for that cycle's update;
  - underflow clears;
  - rlevel takes its computed value.
  - Flags resume normal evaluation on the first cycle after rclr deasserts.
- Underflow: set when rd_en=1 and rempty=1 and rclr=0. It stays set until reset or rclr. A read against an empty FIFO never moves the pointer.
- Simultaneous events:
  - rd_ok together with a write-pointer change: the level uses both, with no priority issue.
  - ae_thresh changes take effect on the next registered arempty.
- Level above 2**AW indicates a corrupt synchroniser. It is passed through unmodified and must not be saturated.

Optional Feature:
- Macro: WL_AFIFO_AREMPTY_HYST_EN.
- Defined: arempty asserts when rlevel_nxt <= thr. Once asserted, it deasserts only when rlevel_nxt > thr + ae_hyst, with the sum computed AW+2 bits wide (no wrap). Otherwise arempty holds its value. rempty and rclr still force arempty=1.
- Undefined: ae_hyst is ignored and arempty follows the plain compare.

Decomposition:
- Package wl_afifo_pkg:
  - bin2gray and gray2bin functions parametrised on width;
  - the pointer-width rule (AW+1).
- Sub-module wl_gray2bin (parametrised width, combinational), reused by the write-side controller.

Test Plan:
- Reset: assert rrst_b=0 mid-run, asynchronously → rempty=1, arempty=1, rlevel=0, bin_rptr=0 immediately. Release → values hold until a wptr change.
- Fill and drain, AW=3: wptr gray steps to bin 5, no reads → rlevel=5, rempty=0, arempty=0 with TB_DEF=2. Read 3 → arempty=1 at level 2. Read 2 → rempty=1 the cycle after the last rd_ok.
- Wrap: drive 20 writes and reads interleaved so pointers cross 15→0 → gray_rptr stays single-bit-change, rlevel correct across the wrap, no false empty.
- Underflow: rd_en=1 while rempty=1 → rd_ok=0, pointer unchanged, underflow=1 sticky. Pulse rclr → underflow=0.
- Runtime threshold: ae_thresh_vld=1, ae_thresh=6, level 7→6 → arempty=1. ae_thresh_vld=0 → arempty=0 next cycle.
- Hysteresis with macro, thr=2, ae_hyst=2: level 2→3→4 → arempty stays 1; level 5 → arempty=0. Without the macro, arempty=0 at level 3.

Source files
------------

// File: rtl/wl_afifo_pkg.sv
// wl_afifo_pkg: shared helpers for the wl async FIFO family.
//   ptr_w    - pointer width rule: one extra wrap bit above the RAM address.
//   bin2gray - binary to reflected gray, for any width up to MaxPtrW.
//   gray2bin - gray to binary, for any width up to MaxPtrW.
// Narrower values are passed zero-extended. The zero upper bits leave both
// conversions unchanged, so one function body serves every pointer width.
package wl_afifo_pkg;

  localparam int unsigned MaxPtrW = 32;

  function automatic int unsigned ptr_w(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] gray);
    logic [MaxPtrW-1:0] bin;
    bin[MaxPtrW-1] = gray[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wl_gray2bin.sv
// wl_gray2bin: combinational gray-to-binary converter, shared by both
// pointer controllers of the wl async FIFO.
// Ports:
//   gray  input  W  gray-coded value
//   bin   output W  binary value; bit i is the XOR of gray bits i..W-1
module wl_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Resolve MSB first so each bit folds in the already-converted bit above it.
  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/wl_afifo_rctrl.sv
// wl_afifo_rctrl: read-domain controller of the wl async FIFO.
// Owns the read pointer (binary, gray, RAM address) and produces registered
// empty, almost-empty, fill level and a sticky underflow flag from the
// rclk-synchronised gray write pointer.
// Optional feature: define WL_AFIFO_AREMPTY_HYST_EN to give arempty a
// deassert hysteresis of ae_hyst above the threshold.
// Ports:
//   rclk, rrst_b   read clock, asynchronous active-low reset
//   rclr           synchronous clear: pointers hold, flags forced, underflow cleared
//   rd_en          read request
//   r2_gray_wptr   synchronised gray write pointer
//   ae_thresh/_vld runtime almost-empty threshold and its select (else TB_DEF)
//   ae_hyst        deassert hysteresis (macro builds only)
//   rd_ok          read accepted this cycle (combinational)
//   raddr          RAM read address
//   bin_rptr       binary read pointer
//   gray_rptr      gray read pointer, to the wclk synchroniser
//   rempty/arempty registered empty / almost-empty
//   rlevel         registered fill level, not saturated
//   underflow      sticky read-while-empty error
module wl_afifo_rctrl
  import wl_afifo_pkg::*;
#(
  parameter int unsigned AW     = 3,
  parameter int unsigned TB_DEF = 2
) (
  input  logic                rclk,
  input  logic                rrst_b,
  input  logic                rclr,
  input  logic                rd_en,
  input  logic [ptr_w(AW)-1:0] r2_gray_wptr,
  input  logic [ptr_w(AW)-1:0] ae_thresh,
  input  logic                ae_thresh_vld,
  input  logic [ptr_w(AW)-1:0] ae_hyst,
  output logic                rd_ok,
  output logic [AW-1:0]       raddr,
  output logic [ptr_w(AW)-1:0] bin_rptr,
  output logic [ptr_w(AW)-1:0] gray_rptr,
  output logic                rempty,
  output logic                arempty,
  output logic [ptr_w(AW)-1:0] rlevel,
  output logic                underflow
);

  localparam int unsigned PW = ptr_w(AW);

  logic [PW-1:0] r2_bin_wptr;
  logic [PW-1:0] bin_rptr_nxt;
  logic [PW-1:0] gray_rptr_nxt;
  logic [PW-1:0] rlevel_nxt;
  logic [PW-1:0] thr;
  logic          rempty_nxt;
  logic          arempty_nxt;

  wl_gray2bin #(
    .W (PW)
  ) u_wptr_g2b (
    .gray (r2_gray_wptr),
    .bin  (r2_bin_wptr)
  );

  assign rd_ok = rd_en & ~rempty & ~rclr;
  assign raddr = bin_rptr[AW-1:0];

  assign bin_rptr_nxt  = bin_rptr + {{AW{1'b0}}, rd_ok};
  assign gray_rptr_nxt = PW'(bin2gray(MaxPtrW'(bin_rptr_nxt)));
  // Modulo subtraction; a corrupt synchroniser may yield > 2**AW, left as is.
  assign rlevel_nxt    = r2_bin_wptr - bin_rptr_nxt;
  // Evaluated on the next pointer so the last read empties with no bubble.
  assign rempty_nxt    = (gray_rptr_nxt == r2_gray_wptr);
  assign thr           = ae_thresh_vld ? ae_thresh : PW'(TB_DEF);

`ifdef WL_AFIFO_AREMPTY_HYST_EN
  logic [PW:0] thr_hi;

  // One extra bit so thr + ae_hyst cannot wrap.
  assign thr_hi = {1'b0, thr} + {1'b0, ae_hyst};

  always_comb begin
    arempty_nxt = 1'b0;
    if (rclr || rempty_nxt || (rlevel_nxt <= thr)) begin
      arempty_nxt = 1'b1;
    end else if (arempty && ({1'b0, rlevel_nxt} <= thr_hi)) begin
      arempty_nxt = 1'b1;
    end
  end
`else
  logic unused_ae_hyst;

  assign unused_ae_hyst = ^ae_hyst;

  always_comb begin
    arempty_nxt = rclr | (rlevel_nxt <= thr);
  end
`endif

  always_ff @(posedge rclk or negedge rrst_b) begin
    if (!rrst_b) begin
      bin_rptr  <= '0;
      gray_rptr <= '0;
      rempty    <= 1'b1;
      arempty   <= 1'b1;
      rlevel    <= '0;
      underflow <= 1'b0;
    end else begin
      // rd_ok is low under rclr, so the pointers hold without a separate term.
      bin_rptr  <= bin_rptr_nxt;
      gray_rptr <= gray_rptr_nxt;
      rlevel    <= rlevel_nxt;
      rempty    <= rclr | rempty_nxt;
      arempty   <= arempty_nxt;
      underflow <= rclr ? 1'b0 : (underflow | (rd_en & rempty));
    end
  end

endmodule

// File: tb/tb_wl_afifo_rctrl.sv
// Self-checking bench for wl_afifo_rctrl (AW=3, TB_DEF=2).
module tb_wl_afifo_rctrl;

  localparam int AW     = 3;
  localparam int MOD    = 16;
  localparam int TB_DEF = 2;
`ifdef WL_AFIFO_AREMPTY_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rrst_b;
  logic          rclr;
  logic          rd_en;
  logic [AW:0]   r2_gray_wptr;
  logic [AW:0]   ae_thresh;
  logic          ae_thresh_vld;
  logic [AW:0]   ae_hyst;
  logic          rd_ok;
  logic [AW-1:0] raddr;
  logic [AW:0]   bin_rptr;
  logic [AW:0]   gray_rptr;
  logic          rempty;
  logic          arempty;
  logic [AW:0]   rlevel;
  logic          underflow;

  wl_afifo_rctrl #(
    .AW     (AW),
    .TB_DEF (TB_DEF)
  ) dut (
    .rclk          (rclk),
    .rrst_b        (rrst_b),
    .rclr          (rclr),
    .rd_en         (rd_en),
    .r2_gray_wptr  (r2_gray_wptr),
    .ae_thresh     (ae_thresh),
    .ae_thresh_vld (ae_thresh_vld),
    .ae_hyst       (ae_hyst),
    .rd_ok         (rd_ok),
    .raddr         (raddr),
    .bin_rptr      (bin_rptr),
    .gray_rptr     (gray_rptr),
    .rempty        (rempty),
    .arempty       (arempty),
    .rlevel        (rlevel),
    .underflow     (underflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int rptr;
    int lvl;
    bit empty;
    bit ae;
    bit uf;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Bench model state.
  int m_rptr = 0;
  int m_wptr = 0;
  int m_lvl  = 0;
  bit m_empty = 1'b1;
  bit m_ae    = 1'b1;
  bit m_uf    = 1'b0;

  function automatic logic [AW:0] g(input int b);
    logic [AW:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // One clock: drive, check rd_ok, push expectation, clock, pop and compare.
  task automatic step(input bit rd, input bit clr);
    exp_t e;
    exp_t o;
    int   thr;
    bit   ok;
    rd_en = rd;
    rclr = clr;
    r2_gray_wptr = g(m_wptr);
    #1;
    ok = rd && !m_empty && !clr;
    total++;
    if (rd_ok !== ok) begin
      bad++;
      $display("FAIL rd_ok: got %b want %b", rd_ok, ok);
    end
    thr = ae_thresh_vld ? int'(ae_thresh) : TB_DEF;
    e.rptr  = (m_rptr + int'(ok)) % MOD;
    e.lvl   = (m_wptr - e.rptr + MOD) % MOD;
    e.empty = clr || (e.lvl == 0);
    if (HYST) e.ae = clr || (e.lvl <= thr) || (m_ae && (e.lvl <= thr + int'(ae_hyst)));
    else      e.ae = clr || (e.lvl <= thr);
    e.uf = clr ? 1'b0 : (m_uf || (rd && m_empty));
    sbq.push_back(e);
    @(posedge rclk);
    #1;
    o = sbq.pop_front();
    total++;
    if (bin_rptr !== 4'(o.rptr) || raddr !== 3'(o.rptr) || gray_rptr !== g(o.rptr)) begin
      bad++;
      $display("FAIL ptr: got bin=%0d raddr=%0d gray=%b want bin=%0d gray=%b",
               bin_rptr, raddr, gray_rptr, o.rptr, g(o.rptr));
    end
    total++;
    if (rlevel !== 4'(o.lvl)) begin
      bad++;
      $display("FAIL rlevel: got %0d want %0d", rlevel, o.lvl);
    end
    total++;
    if (rempty !== o.empty || arempty !== o.ae) begin
      bad++;
      $display("FAIL flags: got rempty=%b arempty=%b want %b %b", rempty, arempty, o.empty, o.ae);
    end
    total++;
    if (underflow !== o.uf) begin
      bad++;
      $display("FAIL underflow: got %b want %b", underflow, o.uf);
    end
    m_rptr = o.rptr; m_lvl = o.lvl; m_empty = o.empty; m_ae = o.ae; m_uf = o.uf;
  endtask

  task automatic wr_step(input bit rd);
    m_wptr = (m_wptr + 1) % MOD;
    step(rd, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) wr_step(1'b0);
    #2;
    rrst_b = 1'b0;
    #1;
    total++;
    if (bin_rptr !== 4'd0 || rlevel !== 4'd0 || rempty !== 1'b1 || arempty !== 1'b1 ||
        underflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got rptr=%0d lvl=%0d e=%b ae=%b uf=%b want 0 0 1 1 0",
               bin_rptr, rlevel, rempty, arempty, underflow);
    end
    m_rptr = 0; m_wptr = 0; m_lvl = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    r2_gray_wptr = '0;
    @(negedge rclk);
    rrst_b = 1'b1;
    @(posedge rclk);
    #1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) wr_step(1'b0);
    total++;
    if (rlevel !== 4'd5 || rempty !== 1'b0 || arempty !== 1'b0) begin
      bad++;
      $display("FAIL fill5: got lvl=%0d e=%b ae=%b want 5 0 0", rlevel, rempty, arempty);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    total++;
    if (rlevel !== 4'd2 || arempty !== 1'b1) begin
      bad++;
      $display("FAIL drain_to_2: got lvl=%0d ae=%b want 2 1", rlevel, arempty);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    total++;
    if (rempty !== 1'b1 || bin_rptr !== 4'd5) begin
      bad++;
      $display("FAIL drain_empty: got e=%b rptr=%0d want 1 5", rempty, bin_rptr);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b0);
    total++;
    if (underflow !== 1'b1 || bin_rptr !== 4'd5) begin
      bad++;
      $display("FAIL underflow_set: got uf=%b rptr=%0d want 1 5", underflow, bin_rptr);
    end
    step(1'b0, 1'b0);
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky: got %b want 1", underflow);
    end
    step(1'b0, 1'b1);
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear: got %b want 0", underflow);
    end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    logic [AW:0] diff;
    for (int i = 0; i < 20; i++) begin
      prev = gray_rptr;
      wr_step(!m_empty);
      diff = prev ^ gray_rptr;
      total++;
      if ($countones(diff) > 1 || rempty !== 1'b0) begin
        bad++;
        $display("FAIL wrap: gray %b->%b e=%b want <=1 bit change, e=0", prev, gray_rptr, rempty);
      end
    end
    while (!m_empty) step(1'b1, 1'b0);
    total++;
    if (bin_rptr !== 4'd9) begin
      bad++;
      $display("FAIL wrap_end: got rptr=%0d want 9", bin_rptr);
    end
  endtask

  task automatic test_thresh();
    ae_thresh_vld = 1'b1;
    ae_thresh = 4'd6;
    ae_hyst = '0;
    for (int i = 0; i < 7; i++) wr_step(1'b0);
    total++;
    if (rlevel !== 4'd7 || arempty !== 1'b0) begin
      bad++;
      $display("FAIL thr_lvl7: got lvl=%0d ae=%b want 7 0", rlevel, arempty);
    end
    step(1'b1, 1'b0);
    total++;
    if (arempty !== 1'b1) begin
      bad++;
      $display("FAIL thr_lvl6: got ae=%b want 1", arempty);
    end
    ae_thresh_vld = 1'b0;
    step(1'b0, 1'b0);
    total++;
    if (arempty !== 1'b0) begin
      bad++;
      $display("FAIL thr_default: got ae=%b want 0", arempty);
    end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b1);
    total++;
    if (rempty !== 1'b1 || arempty !== 1'b1 || rlevel !== 4'd6 || bin_rptr !== 4'd10) begin
      bad++;
      $display("FAIL clear: got e=%b ae=%b lvl=%0d rptr=%0d want 1 1 6 10",
               rempty, arempty, rlevel, bin_rptr);
    end
    step(1'b0, 1'b0);
    total++;
    if (rempty !== 1'b0 || arempty !== 1'b0) begin
      bad++;
      $display("FAIL clear_resume: got e=%b ae=%b want 0 0", rempty, arempty);
    end
  endtask

  task automatic test_hyst();
    ae_hyst = 4'd2;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    total++;
    if (rlevel !== 4'd2 || arempty !== 1'b1) begin
      bad++;
      $display("FAIL hyst_lvl2: got lvl=%0d ae=%b want 2 1", rlevel, arempty);
    end
    wr_step(1'b0);
    total++;
    if (arempty !== HYST) begin
      bad++;
      $display("FAIL hyst_lvl3: got ae=%b want %b", arempty, HYST);
    end
    wr_step(1'b0);
    total++;
    if (arempty !== HYST) begin
      bad++;
      $display("FAIL hyst_lvl4: got ae=%b want %b", arempty, HYST);
    end
    wr_step(1'b0);
    total++;
    if (arempty !== 1'b0 || rlevel !== 4'd5) begin
      bad++;
      $display("FAIL hyst_lvl5: got ae=%b lvl=%0d want 0 5", arempty, rlevel);
    end
  endtask

  task automatic test_corrupt();
    m_wptr = (m_rptr + 12) % MOD;
    step(1'b0, 1'b0);
    total++;
    if (rlevel !== 4'd12) begin
      bad++;
      $display("FAIL corrupt_level: got %0d want 12", rlevel);
    end
  endtask

  initial begin
    rrst_b = 1'b0;
    rclr = 1'b0;
    rd_en = 1'b0;
    r2_gray_wptr = '0;
    ae_thresh = '0;
    ae_thresh_vld = 1'b0;
    ae_hyst = '0;
    #12;
    total++;
    if (rempty !== 1'b1 || arempty !== 1'b1 || bin_rptr !== 4'd0 || gray_rptr !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: got e=%b ae=%b rptr=%0d gray=%0d want 1 1 0 0",
               rempty, arempty, bin_rptr, gray_rptr);
    end
    @(negedge rclk);
    rrst_b = 1'b1;
    @(posedge rclk);
    #1;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_thresh();
    test_clear();
    test_hyst();
    test_corrupt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
